// File: rtl/sfu_accum.sv
// rtl/sfu_accum.sv - multi-pass saturating psum accumulator with optional ReLU
// Pops acc_len psum vectors from the corelet, sums them per lane with clamping, then holds the result.
module sfu_accum #(
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             acc_len,
  input  logic                   relu_en,
  input  logic [psum_bw*col-1:0] in_data,
  input  logic                   in_valid,
  output logic                   o_rd,
  output logic [psum_bw*col-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                   state, state_nxt;
  logic [3:0]               cnt_q;
  logic [3:0]               len_q;
  logic                     relu_q;
  logic [psum_bw*col-1:0]   acc_q;
  logic [psum_bw*col-1:0]   sum_all;
  logic [psum_bw*col-1:0]   post_all;
  logic [psum_bw*col-1:0]   out_q;
  logic                     done_q;
  logic                     accept;
  logic                     last_pop;

  // One extra bit of headroom per lane; a sign/carry disagreement means the add overflowed.
  for (genvar i = 0; i < col; i++) begin : g_lane
    logic signed [psum_bw-1:0] lane_acc;
    logic signed [psum_bw-1:0] lane_in;
    logic signed [psum_bw:0]   wide;
    logic signed [psum_bw-1:0] lane_sat;

    assign lane_acc = acc_q[psum_bw*i +: psum_bw];
    assign lane_in  = in_data[psum_bw*i +: psum_bw];
    assign wide     = {lane_acc[psum_bw-1], lane_acc} + {lane_in[psum_bw-1], lane_in};

    always_comb begin
      lane_sat = wide[psum_bw-1:0];
      if (wide[psum_bw] != wide[psum_bw-1]) begin
        lane_sat = wide[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      end
    end

    assign sum_all[psum_bw*i +: psum_bw]  = lane_sat;
    assign post_all[psum_bw*i +: psum_bw] = (relu_q && lane_sat[psum_bw-1]) ? '0 : lane_sat;
  end

  assign accept   = (state == IDLE) && start && (acc_len != 4'd0);
  assign o_rd     = (state == ACC) && in_valid;
  assign last_pop = o_rd && ((cnt_q + 4'd1) == len_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = ACC;
      ACC:  if (last_pop) state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt_q  <= '0;
      len_q  <= '0;
      relu_q <= 1'b0;
      acc_q  <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == OUT) && out_ready;
      if (accept) begin
        len_q  <= acc_len;
        relu_q <= relu_en;
        cnt_q  <= '0;
        acc_q  <= '0;
      end else if (o_rd) begin
        cnt_q <= cnt_q + 4'd1;
        acc_q <= sum_all;
        // The final add's post-processed result is captured so out_data is a clean register.
        if (last_pop) out_q <= post_all;
      end
    end
  end

  assign out_data  = out_q;
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign done      = done_q;

endmodule

// File: doc/sfu_accum.md
SFU_ACCUM -- requirements
Module: sfu_accum

Interface
REQ-001 Parameter psum_bw, default 16: width of one signed partial-sum lane.
REQ-002 Parameter col, default 8: number of lanes, matching the corelet output width.
REQ-003 Port clk, input, 1: single clock; every flop uses its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: single-cycle request to begin one accumulation pass.
REQ-006 Port acc_len, input, 4: number of psum vectors to sum per pass (1..15); sampled at start.
REQ-007 Port relu_en, input, 1: apply ReLU to the result; sampled at start.
REQ-008 Port in_data, input, psum_bw*col: psum vector from corelet_out; lane i = bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-009 Port in_valid, input, 1: corelet o_valid; in_data holds a complete vector.
REQ-010 Port o_rd, output, 1: pop strobe driven to corelet inst[6] (ofifo_rd).
REQ-011 Port out_data, output, psum_bw*col: accumulated and post-processed vector, same lane packing as in_data.
REQ-012 Port out_valid, output, 1: out_data is valid.
REQ-013 Port out_ready, input, 1: downstream accepts out_data.
REQ-014 Port busy, output, 1: high in any state other than IDLE.
REQ-015 Port done, output, 1: one-cycle pulse when a result is accepted.

Function
REQ-016 The block SHALL implement the states IDLE, ACC and OUT; busy = (state != IDLE).
REQ-017 IDLE: when start=1 and acc_len!=0, the block SHALL latch acc_len and relu_en, clear all lane accumulators and the count to 0, and enter ACC on the next edge.
REQ-018 IDLE: start=1 with acc_len=0 SHALL be ignored; the block remains in IDLE and done is not pulsed.
REQ-019 start SHALL be ignored in ACC and OUT; the latched acc_len and relu_en are not changed.
REQ-020 o_rd SHALL be combinational: o_rd = (state==ACC) & in_valid; o_rd SHALL be 0 in every other state.
REQ-021 On each edge where o_rd=1, each lane accumulator SHALL take sat(acc + in_data lane) and count SHALL increment by 1.
- Lane values are signed two's complement, psum_bw bits wide.
- sat() clamps to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-022 Saturation SHALL be evaluated per lane on every add; a saturated lane stays clamped until a later add brings it back into range.
REQ-023 When count reaches the latched acc_len on an o_rd edge, the next state SHALL be OUT; that edge includes the final add.
REQ-024 In ACC with in_valid=0, the accumulators, count and state SHALL hold; there is no timeout.
REQ-025 OUT: out_valid=1, and out_data lane i = (relu_en and acc_i<0) ? 0 : acc_i; the output is registered and stable while out_valid=1.
REQ-026 OUT: on an edge with out_ready=1, the block SHALL return to IDLE and pulse done=1 for exactly the next cycle.
- If start is high in that done cycle (state IDLE), it SHALL be accepted normally.
REQ-027 OUT with out_ready=0: out_valid and out_data SHALL hold indefinitely, and no pop occurs.
REQ-028 Latency with in_valid held high: start at edge 0 gives o_rd high in cycles 1..acc_len and out_valid from cycle acc_len+1.
- With out_ready high, done is high in cycle acc_len+2.
REQ-029 out_valid SHALL be 0 whenever state != OUT.

Reset
REQ-030 Reset assertion SHALL immediately, without a clock, force the following regardless of state, including mid-ACC and mid-OUT:
- state=IDLE, count=0, all accumulators=0;
- latched acc_len=0, latched relu_en=0;
- out_data=0, out_valid=0, done=0, busy=0, o_rd=0.
REQ-031 After reset deassertion, the first start SHALL be honoured on the first rising edge at which reset is low.

Verification
REQ-032 Basic sum: acc_len=3, relu_en=0, lane0 inputs 5, -2, 10 with in_valid held high -> o_rd high 3 cycles; out lane0=13; done pulses once after out_ready.
REQ-033 ReLU: acc_len=2, relu_en=1, lane0 inputs -7, 3 and lane1 inputs 4, 4 -> out lane0=0, lane1=8.
REQ-034 Saturation (psum_bw=16): acc_len=2, lane0 inputs 30000, 30000 -> lane0=32767; lane1 inputs -30000, -30000 -> lane1=-32768.
REQ-035 Stall: in_valid toggles 1,0,0,1 with acc_len=2 -> o_rd mirrors in_valid; the sum uses only the two popped vectors. Then out_ready low for 5 cycles -> out_data stable and no extra o_rd.
REQ-036 Ignored start and zero length: start pulsed during ACC with a different acc_len -> no effect on the pass. start with acc_len=0 in IDLE -> busy stays 0.
REQ-037 Reset mid-operation: assert reset asynchronously mid-ACC after 1 of 4 pops -> all outputs 0 immediately. A subsequent pass with acc_len=1, input 9 -> out lane0=9, with no residue from the aborted pass.
